// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, result-mux select codes,
// dispatcher state and unit encodings.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    // Result-mux source codes; the result mux imports these as well.
    localparam logic [1:0] SEL_ADDSUB = 2'd0;
    localparam logic [1:0] SEL_XORRED = 2'd1;
    localparam logic [1:0] SEL_PADDSB = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        UNIT_ADDSUB = 2'd0,
        UNIT_XOR    = 2'd1,
        UNIT_RED    = 2'd2,
        UNIT_PADDSB = 2'd3
    } unit_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Request, unit-control and result signals between the requester (master)
// and the ALU dispatcher (slave).
interface alu_dispatch_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_sub;
    logic          go_addsub;
    logic          go_xor;
    logic          go_red;
    logic          go_paddsb;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_opcode;
    logic [1:0]    res_sel;
    logic          err;

    modport master (
        output in_valid, in_opcode, in_a, in_b, res_ready,
        input  in_ready, op_a, op_b, op_sub, go_addsub, go_xor, go_red, go_paddsb,
        input  res_valid, res_opcode, res_sel, err
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, res_ready,
        output in_ready, op_a, op_b, op_sub, go_addsub, go_xor, go_red, go_paddsb,
        output res_valid, res_opcode, res_sel, err
    );
endinterface

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that tracks the remaining latency of the running unit.
module alu_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);
    logic [W-1:0] r_count;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
endmodule

// File: rtl/alu_dispatch.sv
// ALU issue-side controller: decodes an opcode into a one-cycle unit start,
// holds the operands, waits out the unit latency and presents the result select.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int DW         = 16,
    parameter int LAT_ADDSUB = 1,
    parameter int LAT_XOR    = 1,
    parameter int LAT_RED    = 3,
    parameter int LAT_PADDSB = 2
) (
    input logic           clk,
    input logic           rst,
    alu_dispatch_if.slave bus
);
    localparam int MAX_LAT = max4(LAT_ADDSUB, LAT_XOR, LAT_RED, LAT_PADDSB);
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t        r_state;
    state_t        w_state_nxt;
    unit_t         r_unit;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic          r_op_sub;
    logic [3:0]    r_opcode;
    logic [1:0]    r_res_sel;
    logic          r_err;

    logic          w_legal;
    unit_t         w_unit;
    logic [1:0]    w_sel;
    logic [CW-1:0] w_lat_m1;
    logic          w_accept;
    logic          w_load;
    logic [CW-1:0] w_cnt;
    logic          w_cnt_zero;
    logic          w_in_ready;
    logic          w_go_addsub;
    logic          w_go_xor;
    logic          w_go_red;
    logic          w_go_paddsb;
    logic          w_res_valid;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_legal  = 1'b1;
        w_unit   = UNIT_ADDSUB;
        w_sel    = SEL_ADDSUB;
        w_lat_m1 = CW'(LAT_ADDSUB - 1);
        case (bus.in_opcode)
            OP_ADD, OP_SUB: ;
            OP_XOR: begin
                w_unit   = UNIT_XOR;
                w_sel    = SEL_XORRED;
                w_lat_m1 = CW'(LAT_XOR - 1);
            end
            OP_RED: begin
                w_unit   = UNIT_RED;
                w_sel    = SEL_XORRED;
                w_lat_m1 = CW'(LAT_RED - 1);
            end
            OP_PADDSB: begin
                w_unit   = UNIT_PADDSB;
                w_sel    = SEL_PADDSB;
                w_lat_m1 = CW'(LAT_PADDSB - 1);
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
    assign w_load   = w_accept && w_legal;

    alu_lat_counter #(.W(CW)) u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_lat_m1),
        .i_dec      (r_state == ST_WAIT),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_load) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = w_cnt_zero ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (w_cnt == CW'(1)) w_state_nxt = ST_RESP;
            ST_RESP:  if (bus.res_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_go_addsub = 1'b0;
        w_go_xor    = 1'b0;
        w_go_red    = 1'b0;
        w_go_paddsb = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            ST_IDLE:  w_in_ready = 1'b1;
            ST_ISSUE: begin
                w_go_addsub = (r_unit == UNIT_ADDSUB);
                w_go_xor    = (r_unit == UNIT_XOR);
                w_go_red    = (r_unit == UNIT_RED);
                w_go_paddsb = (r_unit == UNIT_PADDSB);
            end
            ST_RESP:  w_res_valid = 1'b1;
            default:  ;
        endcase
    end

    // Operands and result select change only on a legal accept; illegal ones just flag err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_sub  <= 1'b0;
            r_opcode  <= OP_ADD;
            r_res_sel <= SEL_ADDSUB;
            r_unit    <= UNIT_ADDSUB;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_load) begin
                r_op_a    <= bus.in_a;
                r_op_b    <= bus.in_b;
                r_op_sub  <= (bus.in_opcode == OP_SUB);
                r_opcode  <= bus.in_opcode;
                r_res_sel <= w_sel;
                r_unit    <= w_unit;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.op_a       = r_op_a;
    assign bus.op_b       = r_op_b;
    assign bus.op_sub     = r_op_sub;
    assign bus.go_addsub  = w_go_addsub;
    assign bus.go_xor     = w_go_xor;
    assign bus.go_red     = w_go_red;
    assign bus.go_paddsb  = w_go_paddsb;
    assign bus.res_valid  = w_res_valid;
    assign bus.res_opcode = r_opcode;
    assign bus.res_sel    = r_res_sel;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: stimulus pushes expected results into a
// scoreboard queue, a monitor pops and compares on each result handshake.
module tb_alu_dispatch;
    import alu_pkg::*;

    typedef struct {
        logic [3:0]  opc;
        logic [1:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_dispatch_if #(.DW(16)) bus ();

    alu_dispatch #(
        .DW(16), .LAT_ADDSUB(1), .LAT_XOR(1), .LAT_RED(3), .LAT_PADDSB(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gov();
        return {bus.go_addsub, bus.go_xor, bus.go_red, bus.go_paddsb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,   1);
        check({tag, "_go"},        gov(),          4'b0000);
        check({tag, "_res_valid"}, bus.res_valid,  0);
        check({tag, "_err"},       bus.err,        0);
        check({tag, "_op_a"},      bus.op_a,       16'h0000);
        check({tag, "_op_b"},      bus.op_b,       16'h0000);
        check({tag, "_op_sub"},    bus.op_sub,     0);
        check({tag, "_res_opc"},   bus.res_opcode, 4'b0000);
        check({tag, "_res_sel"},   bus.res_sel,    2'd0);
    endtask

    // Present a request for the current cycle; the next edge accepts it.
    task automatic issue(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] sel, input bit legal);
        exp_t e;
        check("accept_in_ready", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.in_opcode = opc;
        bus.in_a      = a;
        bus.in_b      = b;
        if (legal) begin
            e.opc = opc; e.sel = sel; e.a = a; e.b = b; e.sub = (opc == OP_SUB);
            sb.push_back(e);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compares every result handshake against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_res_valid", bus.res_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_res_opcode", bus.res_opcode, e.opc);
                    check("sb_res_sel",    bus.res_sel,    e.sel);
                    check("sb_op_a",       bus.op_a,       e.a);
                    check("sb_op_b",       bus.op_b,       e.b);
                    check("sb_op_sub",     bus.op_sub,     e.sub);
                end
            end
        end
    end

    initial begin
        int acc[$];
        int gos;
        int n_acc;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 4'b0000;
        bus.in_a      = 16'h0000;
        bus.in_b      = 16'h0000;
        bus.res_ready = 1'b1;
        repeat (3) step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        // ADD: go in cycle 1, result in cycle 2
        issue(OP_ADD, 16'h0005, 16'h0003, SEL_ADDSUB, 1);
        check("add_go",        gov(),         4'b1000);
        check("add_op_a",      bus.op_a,      16'h0005);
        check("add_op_sub",    bus.op_sub,    0);
        check("add_in_ready1", bus.in_ready,  0);
        check("add_valid1",    bus.res_valid, 0);
        step();
        check("add_valid2",    bus.res_valid, 1);
        check("add_res_sel",   bus.res_sel,   2'd0);
        check("add_go_done",   gov(),         4'b0000);
        step();
        check("add_in_ready3", bus.in_ready,  1);

        // SUB
        issue(OP_SUB, 16'h0010, 16'h0004, SEL_ADDSUB, 1);
        check("sub_go",        gov(),          4'b1000);
        check("sub_op_sub",    bus.op_sub,     1);
        step();
        check("sub_valid",     bus.res_valid,  1);
        check("sub_res_opc",   bus.res_opcode, 4'b0001);
        step();

        // RED with res_ready stalled for 5 cycles
        bus.res_ready = 1'b0;
        issue(OP_RED, 16'h00F0, 16'h000F, SEL_XORRED, 1);
        check("red_go",        gov(),         4'b0010);
        check("red_in_ready1", bus.in_ready,  0);
        for (int c = 2; c <= 3; c++) begin
            step();
            check("red_not_valid", bus.res_valid, 0);
            check("red_in_ready",  bus.in_ready,  0);
            check("red_go_low",    gov(),         4'b0000);
        end
        for (int c = 4; c <= 8; c++) begin
            step();
            check("red_hold_valid", bus.res_valid,  1);
            check("red_hold_opc",   bus.res_opcode, 4'b0011);
            check("red_hold_sel",   bus.res_sel,    2'd1);
            check("red_hold_op_a",  bus.op_a,       16'h00F0);
            check("red_hold_ready", bus.in_ready,   0);
        end
        step();
        check("red_valid9", bus.res_valid, 1);
        bus.res_ready = 1'b1;
        step();
        check("red_release_ready", bus.in_ready,  1);
        check("red_release_valid", bus.res_valid, 0);

        // Illegal opcode 0101
        issue(4'b0101, 16'hDEAD, 16'hBEEF, SEL_ADDSUB, 0);
        check("ill_err1",      bus.err,       1);
        check("ill_go",        gov(),         4'b0000);
        check("ill_in_ready1", bus.in_ready,  1);
        check("ill_op_a",      bus.op_a,      16'h00F0);
        check("ill_op_b",      bus.op_b,      16'h000F);
        step();
        check("ill_err2",      bus.err,       0);
        check("ill_in_ready2", bus.in_ready,  1);
        check("ill_valid2",    bus.res_valid, 0);

        // PADDSB abandoned by reset in its WAIT cycle
        issue(OP_PADDSB, 16'h7F80, 16'h0180, SEL_PADDSB, 1);
        check("pad_go", gov(), 4'b0001);
        step();
        check("pad_wait_valid", bus.res_valid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        check_reset_vals("midrst");
        for (int c = 0; c < 3; c++) begin
            step();
            check("midrst_no_valid", bus.res_valid, 0);
        end

        // XOR after the reset completes normally
        issue(OP_XOR, 16'h1234, 16'h00FF, SEL_XORRED, 1);
        check("xor_go", gov(), 4'b0100);
        step();
        check("xor_valid", bus.res_valid, 1);
        check("xor_sel",   bus.res_sel,   2'd1);
        step();

        // Back-to-back XORs with in_valid held high
        gos   = 0;
        n_acc = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.go_xor) gos++;
            if (n_acc < 3) begin
                exp_t e;
                bus.in_valid  = 1'b1;
                bus.in_opcode = OP_XOR;
                bus.in_a      = 16'h0100 + 16'(n_acc);
                bus.in_b      = 16'h00FF;
                if (bus.in_ready) begin
                    e.opc = OP_XOR; e.sel = SEL_XORRED; e.a = bus.in_a; e.b = bus.in_b; e.sub = 1'b0;
                    sb.push_back(e);
                    acc.push_back(c);
                    n_acc++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
        end
        check("b2b_accepts", n_acc, 3);
        if (acc.size() == 3) begin
            check("b2b_gap1", acc[1] - acc[0], 3);
            check("b2b_gap2", acc[2] - acc[1], 3);
        end
        check("b2b_go_pulses", gos, 3);

        repeat (4) step();
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
